// File: rtl/ctr_pkg.sv
// Shared encodings for the MIO counter window: channel modes, register select
// and CTRL/STATUS bit positions.
package ctr_pkg;

  typedef enum logic [1:0] {
    CTR_ONESHOT = 2'b00,
    CTR_RATE    = 2'b01,
    CTR_SQUARE  = 2'b10,
    CTR_FREE    = 2'b11
  } ctr_mode_e;

  localparam logic SEL_LOAD = 1'b0;
  localparam logic SEL_CTRL = 1'b1;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IE      = 3;
  localparam int CTRL_OUT     = 4;
  localparam int CTRL_FLAG    = 5;
  localparam int STATUS_W     = 6;

endpackage

// File: rtl/counter_channel.sv
// One programmable down-counter/timer channel: LOAD/COUNT and CTRL registers,
// mode-dependent counting, registered output bit and sticky flag.
module counter_channel
  import ctr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                sel,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                tick,
  output logic [WIDTH-1:0]    cnt,
  output logic [STATUS_W-1:0] status,
  output logic                cnt_out,
  output logic                irq_req
);

  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  ctr_mode_e        mode_q, mode_d;
  logic             ie_q, ie_d;
  logic             out_q, out_d;
  logic             flag_q, flag_d;
  logic             terminal;
  logic             counting;

  // cnt == 0 or cnt == 1; LOAD=0 therefore reloads on every tick.
  assign terminal = (cnt_q[WIDTH-1:1] == '0);
  // A write to this channel takes priority and swallows the tick.
  assign counting = en_q && tick && !we;

  always_comb begin
    load_d = load_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    mode_d = mode_q;
    ie_d   = ie_q;
    out_d  = out_q;
    flag_d = flag_q;
    // Rate-mode pulse lasts a single clock.
    if (mode_q == CTR_RATE) out_d = 1'b0;

    if (we && sel == SEL_LOAD) begin
      load_d = wdata;
      cnt_d  = wdata;
      out_d  = (mode_q == CTR_FREE) ? wdata[WIDTH-1] : 1'b0;
      flag_d = 1'b0;
    end else if (we && sel == SEL_CTRL) begin
      en_d   = wdata[CTRL_EN];
      mode_d = ctr_mode_e'(wdata[CTRL_MODE_HI:CTRL_MODE_LO]);
      ie_d   = wdata[CTRL_IE];
      flag_d = 1'b0;
      if (mode_d != mode_q) out_d = 1'b0;
    end else if (counting) begin
      unique case (mode_q)
        CTR_ONESHOT: begin
          if (cnt_q == WIDTH'(1)) begin
            cnt_d  = '0;
            out_d  = 1'b1;
            flag_d = 1'b1;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
        CTR_RATE, CTR_SQUARE: begin
          if (terminal) begin
            cnt_d  = load_q;
            out_d  = (mode_q == CTR_RATE) ? 1'b1 : ~out_q;
            flag_d = 1'b1;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
        CTR_FREE: begin
          cnt_d = cnt_q + WIDTH'(1);
          out_d = cnt_d[WIDTH-1];
          if (cnt_q == '1) flag_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      mode_q <= CTR_ONESHOT;
      ie_q   <= 1'b0;
      out_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      load_q <= load_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      ie_q   <= ie_d;
      out_q  <= out_d;
      flag_q <= flag_d;
    end
  end

  assign cnt     = cnt_q;
  assign status  = {flag_q, out_q, ie_q, mode_q, en_q};
  assign cnt_out = out_q;
  assign irq_req = flag_q & ie_q;

endmodule

// File: rtl/counter_bank.sv
// Multi-channel programmable counter/timer for the MIO bus counter window:
// address decode, combinational read mux and registered interrupt.
module counter_bank
  import ctr_pkg::*;
#(
  parameter  int N_CH   = 3,
  parameter  int WIDTH  = 32,
  localparam int ADDR_W = $clog2(N_CH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   tick,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic [N_CH-1:0]   cnt_out,
  output logic              irq
);

  logic                sel;
  logic [ADDR_W-2:0]   ch_idx;
  logic [WIDTH-1:0]    cnt_arr    [N_CH];
  logic [STATUS_W-1:0] status_arr [N_CH];
  logic [N_CH-1:0]     irq_req;

  assign sel    = addr[0];
  assign ch_idx = addr[ADDR_W-1:1];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    counter_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .we      (we && (ch_idx == (ADDR_W-1)'(i))),
      .sel     (sel),
      .wdata   (wdata),
      .tick    (tick[i]),
      .cnt     (cnt_arr[i]),
      .status  (status_arr[i]),
      .cnt_out (cnt_out[i]),
      .irq_req (irq_req[i])
    );
  end

  // Unpopulated channel indices read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_idx == (ADDR_W-1)'(i)) begin
        rdata = (sel == SEL_CTRL) ? WIDTH'(status_arr[i]) : cnt_arr[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |irq_req;
  end

endmodule
